fifo_rd_stream_bridge: RTL and testbench

Read-side consumer of the asynchronous FIFO, running entirely in the read clock domain. It drives the FIFO read enable, absorbs the one-cycle registered RAM read latency, and presents the words as a valid/ready stream to the downstream datapath at up to one word per cycle. It also supports a synchronous flush and keeps a running count of delivered words.

---
 rtl/fifo_rd_pkg.sv | 14 +
 rtl/rd_skid_buf.sv | 67 ++++++
 rtl/fifo_rd_stream_bridge.sv | 65 ++++++
 tb/tb_fifo_rd_stream_bridge.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared constants and helpers for the FIFO read-side stream bridge.
package fifo_rd_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;
  localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);

  // Occupancy counter width: must hold 0..DEPTH, plus the in-flight word
  // when the issue rule sums count and inflight.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// DEPTH-entry circular buffer absorbing the FIFO RAM read latency.
// Entries are reset to zero so dout is defined straight out of reset.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;
  logic                         do_push;
  logic                         do_pop;

  // Clear wins over both; a pop on an empty buffer is ignored.
  assign do_push = push & ~clear;
  assign do_pop  = pop & ~clear & (count != '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      // One storage entry, written when the write pointer selects it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          mem[gi] <= '0;
        else if (do_push && (wr_ptr == PW'(gi)))
          mem[gi] <= din;
      end
    end
  endgenerate

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream_bridge.sv
// Read-domain consumer of the async FIFO: issues reads, captures the
// registered RAM data a cycle later and presents it as valid/ready.
module fifo_rd_stream_bridge
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_r_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  beat_count
);

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0] count;
  logic [CW-1:0] occ;
  logic          inflight;
  logic          push;
  logic          pop;

  // Reserve a slot for the word already requested so capture never overflows.
  assign occ       = count + CW'(inflight);
  assign fifo_r_en = rrst & ~flush & ~fifo_empty & (occ < CW'(DEPTH));

  assign push    = inflight & ~flush;
  assign m_valid = (count != '0);
  assign pop     = m_valid & m_ready;

  // One-cycle valid pipe tracking the RAM read latency; flush drops it.
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst)      inflight <= 1'b0;
    else if (flush) inflight <= 1'b0;
    else            inflight <= fifo_r_en;
  end

  // Delivered-word counter; a handshake in a flush cycle still counts.
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst)    beat_count <= '0;
    else if (pop) beat_count <= beat_count + 1'b1;
  end

  rd_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk   (rclk),
    .rst_n (rrst),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .din   (fifo_rdata),
    .dout  (m_data),
    .count (count)
  );

endmodule

// File: tb/tb_fifo_rd_stream_bridge.sv
// Bench for fifo_rd_stream_bridge: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fifo_rd_stream_bridge;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;

  logic              rclk = 1'b0;
  logic              rrst = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_rdata = '0;
  logic              fifo_r_en;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready = 1'b0;
  logic              flush = 1'b0;
  logic [CNT_W-1:0]  beat_count;

  int checks   = 0;
  int failures = 0;

  // Environment FIFO contents, model buffer, and delivered-word log.
  logic [DATA_W-1:0] src[$];
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] hs_log[$];
  int                hs_cyc[$];
  bit                m_infl;
  bit                rd_acc;
  bit                force_empty;
  int                m_beat;
  int                n_reads;
  int                cyc = 0;

  fifo_rd_stream_bridge #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .flush      (flush),
    .beat_count (beat_count)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: compare at negedge, then advance to post-edge state.
  always @(negedge rclk) begin
    bit exp_ren;
    bit exp_vld;
    cyc++;
    if (!rrst) begin
      mq.delete();
      m_infl = 1'b0;
      m_beat = 0;
      rd_acc = 1'b0;
      chk("rst_ren",   64'(fifo_r_en),  64'd0);
      chk("rst_valid", 64'(m_valid),    64'd0);
      chk("rst_data",  64'(m_data),     64'd0);
      chk("rst_beat",  64'(beat_count), 64'd0);
    end else begin
      exp_ren = !flush && !fifo_empty && ((mq.size() + int'(m_infl)) < DEPTH);
      exp_vld = (mq.size() != 0);
      chk("ren",   64'(fifo_r_en), 64'(exp_ren));
      chk("valid", 64'(m_valid),   64'(exp_vld));
      if (exp_vld) chk("data", 64'(m_data), 64'(mq[0]));
      chk("beat", 64'(beat_count), 64'(m_beat % (1 << CNT_W)));
      rd_acc = fifo_r_en;
      if (fifo_r_en) n_reads++;
      if (exp_vld && m_ready) begin
        hs_log.push_back(mq[0]);
        hs_cyc.push_back(cyc);
        void'(mq.pop_front());
        m_beat++;
      end
      if (flush) begin
        mq.delete();
        m_infl = 1'b0;
      end else begin
        if (m_infl) mq.push_back(fifo_rdata);
        m_infl = exp_ren;
      end
    end
  end

  // Advance one cycle: the FIFO answers an accepted read with data, then
  // the next cycle's inputs are applied.
  task automatic step(input bit rdy, input bit fl, input bit fe);
    @(posedge rclk);
    #1;
    if (rd_acc && src.size() > 0) fifo_rdata = src.pop_front();
    else                          fifo_rdata = $urandom;
    m_ready     = rdy;
    flush       = fl;
    force_empty = fe;
    fifo_empty  = fe || (src.size() == 0);
  endtask

  task automatic do_reset(input logic [DATA_W-1:0] base, input int n, input bit rdy);
    @(posedge rclk);
    #1;
    rrst  = 1'b0;
    flush = 1'b0;
    m_ready = rdy;
    force_empty = 1'b0;
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(base + DATA_W'(i));
    fifo_empty = (n == 0);
    repeat (3) @(posedge rclk);
    #1;
    chk("hold_rst_data", 64'(m_data), 64'd0);
    chk("hold_rst_ren",  64'(fifo_r_en), 64'd0);
    hs_log.delete();
    hs_cyc.delete();
    n_reads = 0;
    rrst = 1'b1;
    #1;
    chk("release_ren", 64'(fifo_r_en), 64'(n > 0));
  endtask

  task automatic chk_seq(input string nm, input logic [DATA_W-1:0] base, input int n);
    chk({nm, "_count"}, 64'(hs_log.size()), 64'(n));
    for (int i = 0; i < n; i++)
      chk({nm, "_word"}, 64'((i < hs_log.size()) ? hs_log[i] : 32'hDEAD_BEEF),
          64'(base + DATA_W'(i)));
  endtask

  initial begin
    int first;

    // Streaming at full rate.
    do_reset(32'hA0, 8, 1'b1);
    first = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge rclk);
      if (m_valid && first < 0) first = k;
      step(1'b1, 1'b0, 1'b0);
    end
    chk("stream_first_valid", 64'(first), 64'd2);
    chk_seq("stream", 32'hA0, 8);
    chk("stream_gapless", 64'((hs_cyc.size() == 8) ? hs_cyc[7] - hs_cyc[0] : -1), 64'd7);
    chk("stream_beats", 64'(beat_count), 64'd8);

    // Backpressure: only DEPTH reads, head word held.
    do_reset(32'hA0, 8, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0);
    @(negedge rclk);
    chk("bp_reads", 64'(n_reads), 64'd4);
    chk("bp_ren",   64'(fifo_r_en), 64'd0);
    chk("bp_hold",  64'(m_data), 64'hA0);
    repeat (16) step(1'b1, 1'b0, 1'b0);
    @(negedge rclk);
    chk_seq("bp", 32'hA0, 8);

    // FIFO runs dry after three reads.
    do_reset(32'hC0, 3, 1'b1);
    repeat (12) step(1'b1, 1'b0, 1'b0);
    @(negedge rclk);
    chk("dry_reads", 64'(n_reads), 64'd3);
    chk_seq("dry", 32'hC0, 3);
    chk("dry_valid", 64'(m_valid), 64'd0);

    // Flush with two buffered words and one in flight, handshake same cycle.
    do_reset(32'hB0, 8, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    @(negedge rclk);
    chk("flush_pre_data", 64'(m_data), 64'hB0);
    step(1'b0, 1'b0, 1'b0);
    @(negedge rclk);
    chk("flush_post_valid", 64'(m_valid), 64'd0);
    chk("flush_post_beat",  64'(beat_count), 64'd1);
    repeat (14) step(1'b1, 1'b0, 1'b0);
    @(negedge rclk);
    chk("flush_count", 64'(hs_log.size()), 64'd6);
    chk("flush_w0", 64'((hs_log.size() > 0) ? hs_log[0] : 32'hDEAD_BEEF), 64'hB0);
    for (int i = 1; i < 6; i++)
      chk("flush_wn", 64'((i < hs_log.size()) ? hs_log[i] : 32'hDEAD_BEEF), 64'(32'hB2 + i));
    chk("flush_beats", 64'(beat_count), 64'd6);

    // Counter and pointer wrap: 18 beats on a 4-bit counter.
    do_reset(32'h100, 18, 1'b1);
    repeat (30) step(1'b1, 1'b0, 1'b0);
    @(negedge rclk);
    chk("wrap_beat", 64'(beat_count), 64'd2);
    chk_seq("wrap", 32'h100, 18);

    // Randomized traffic against the model.
    do_reset(32'h0, 0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0 && src.size() < 8) begin
        int nw;
        nw = int'($urandom_range(1, 3));
        for (int j = 0; j < nw; j++) src.push_back($urandom);
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15);
    end
    repeat (40) step(1'b1, 1'b0, 1'b0);
    @(negedge rclk);
    chk("drain_valid", 64'(m_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
